host_tx_fifo: RTL and testbench

HOST_TX_FIFO -- requirements
Module: host_tx_fifo

---
 rtl/host_tx_fifo.sv | 106 ++++++++++
 tb/tb_host_tx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/host_tx_fifo.sv
`default_nettype none
// ============================================================================
// host_tx_fifo : byte FIFO from core to the active host interface (FWFT)
// Rev 1.0
// ============================================================================
module host_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    host_mode,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  input  logic          tx_fifo_rd_en,
  output logic [7:0]    tx_fifo_dout,
  output logic          tx_fifo_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          err_clr
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    mode_q, mode_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          rd_ok;
  logic          wr_ok;
  logic          flush_all;
  logic          mem_we;

  assign full          = (count_q == FULL_CNT);
  assign tx_fifo_empty = (count_q == '0);
  assign tx_fifo_dout  = mem[rp_q];
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

  // A pop frees a slot in the same cycle, so a write at full is legal with it.
  assign rd_ok     = tx_fifo_rd_en && !tx_fifo_empty;
  assign wr_ok     = wr_en && (!full || rd_ok);
  assign flush_all = flush || (host_mode != mode_q);
  assign mem_we    = wr_ok && !flush_all;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    mode_d  = host_mode;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (flush_all) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wp_d = wp_q + 1'b1;
      if (rd_ok) rp_d = rp_q + 1'b1;
      if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    end

    // Error flags ignore flush; a set event wins over a same-cycle clear.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en && full && !rd_ok) ovf_d = 1'b1;
    if (tx_fifo_rd_en && tx_fifo_empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      mode_q  <= 2'b00;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wp_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_host_tx_fifo.sv
`default_nettype none
// Directed self-checking bench for host_tx_fifo (DEPTH=16).
module tb_host_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] host_mode;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       tx_fifo_rd_en;
  logic [7:0] tx_fifo_dout;
  logic       tx_fifo_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

  int n_checks = 0;
  int n_errors = 0;

  host_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_mode     (host_mode),
    .flush         (flush),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .tx_fifo_rd_en (tx_fifo_rd_en),
    .tx_fifo_dout  (tx_fifo_dout),
    .tx_fifo_empty (tx_fifo_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    tx_fifo_rd_en = 1'b1;
    tick();
    tx_fifo_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; host_mode = 2'b00; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    tx_fifo_rd_en = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_empty", 32'(tx_fifo_empty), 32'd1);
    chk("rst_full",  32'(full),          32'd0);
    chk("rst_count", 32'(count),         32'd0);
    chk("rst_flags", {overflow, underflow}, 32'd0);
    rst = 1'b0;
    tick();

    // Single byte, write-to-read latency 1
    push(8'hA5);
    chk("wr1_empty", 32'(tx_fifo_empty), 32'd0);
    chk("wr1_dout",  32'(tx_fifo_dout),  32'hA5);
    chk("wr1_count", 32'(count),         32'd1);
    pop();
    chk("pop1_empty", 32'(tx_fifo_empty), 32'd1);
    chk("pop1_count", 32'(count),         32'd0);

    // Fill (pointers start at 1, so they wrap), overflow, drain in order
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ovf",   32'(overflow), 32'd0);
    push(8'hFF);
    chk("ovf_count", 32'(count),    32'd16);
    chk("ovf_flag",  32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), 32'(tx_fifo_dout), 32'(i));
      pop();
    end
    chk("drain_empty", 32'(tx_fifo_empty), 32'd1);
    chk("drain_count", 32'(count),         32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Simultaneous write and pop at full
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    wr_en = 1'b1; wr_data = 8'h55; tx_fifo_rd_en = 1'b1;
    tick();
    wr_en = 1'b0; tx_fifo_rd_en = 1'b0;
    chk("wrrd_count", 32'(count),    32'd16);
    chk("wrrd_head",  32'(tx_fifo_dout), 32'h81);
    chk("wrrd_ovf",   32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("wrrd_drain_%0d", i), 32'(tx_fifo_dout), 32'h80 + 32'(i));
      pop();
    end
    chk("wrrd_last", 32'(tx_fifo_dout), 32'h55);
    pop();
    chk("wrrd_empty", 32'(tx_fifo_empty), 32'd1);

    // Pop while empty with same-cycle write
    wr_en = 1'b1; wr_data = 8'h3C; tx_fifo_rd_en = 1'b1;
    tick();
    wr_en = 1'b0; tx_fifo_rd_en = 1'b0;
    chk("udf_flag",  32'(underflow),    32'd1);
    chk("udf_count", 32'(count),        32'd1);
    chk("udf_dout",  32'(tx_fifo_dout), 32'h3C);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_flags", {overflow, underflow}, 32'd0);
    pop();
    // Set beats clear in the same cycle
    tx_fifo_rd_en = 1'b1; err_clr = 1'b1;
    tick();
    tx_fifo_rd_en = 1'b0; err_clr = 1'b0;
    chk("set_over_clr", 32'(underflow), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_udf", 32'(underflow), 32'd0);

    // Mode-change flush
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    chk("mode_pre_count", 32'(count), 32'd5);
    host_mode = 2'b01;
    tick();
    chk("mode_count", 32'(count),         32'd0);
    chk("mode_empty", 32'(tx_fifo_empty), 32'd1);
    push(8'h20);
    chk("mode_after_count", 32'(count), 32'd1);
    chk("mode_after_dout",  32'(tx_fifo_dout), 32'h20);

    // Explicit flush discards a same-cycle write
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    chk("flush_pre_count", 32'(count), 32'd5);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_count", 32'(count),         32'd0);
    chk("flush_empty", 32'(tx_fifo_empty), 32'd1);
    pop();
    chk("flush_udf", 32'(underflow), 32'd1);
    push(8'h99);
    chk("flush_after_dout",  32'(tx_fifo_dout), 32'h99);
    chk("flush_after_count", 32'(count),        32'd1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
    chk("arst_pre_count", 32'(count), 32'd7);
    rst = 1'b1;
    #2;
    chk("arst_count", 32'(count),         32'd0);
    chk("arst_empty", 32'(tx_fifo_empty), 32'd1);
    chk("arst_full",  32'(full),          32'd0);
    chk("arst_flags", {overflow, underflow}, 32'd0);
    host_mode = 2'b00;
    tick();
    rst = 1'b0;
    push(8'hC3);
    chk("post_rst_dout",  32'(tx_fifo_dout), 32'hC3);
    chk("post_rst_count", 32'(count),        32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
